pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Decodes a PWM waveform back into its duty-cycle code. It is the receive-side counterpart of the team's counter/compare PWM generator, whose period is 2^CTR_LEN clk cycles and whose high time is `compare` cycles.
- Sits on a board-level PWM input, e.g. fan tach/loopback, or checking a remote PWM driver.
- Measures high time and period in clk cycles and reports a recovered compare code with a lock indication.
- Detects a line stuck low or stuck high.

Parameters:
- CTR_LEN, 6: width of the recovered compare code; nominal period is 2^CTR_LEN cycles.
- CNT_W, 16: width of the measurement counters and of high_cnt/period_cnt.
- TIMEOUT, 128: cycles without a rising edge before the line is declared stuck. Must satisfy 2^CTR_LEN < TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  synchronous run enable.
- pwm_in  in  1  asynchronous PWM input.
- high_cnt  out  CNT_W  last measured high time, in cycles.
- period_cnt  out  CNT_W  last measured rise-to-rise period, in cycles.
- compare_out  out  CTR_LEN  recovered duty code.
- valid  out  1  one-cycle pulse when outputs update.
- locked  out  1  last period equalled exactly 2^CTR_LEN.
- stuck_low  out  1  timeout occurred with line low.
- stuck_high  out  1  timeout occurred with line high.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all counters, synchronizer flops and outputs are 0.
- Input conditioning:
  - 2-flop synchronizer s1→s2, plus s3 holding the previous s2.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- States: IDLE, ARM, MEASURE.
- IDLE:
  - Counters held at 0.
  - enable=1 → ARM with period_ctr=0.
  - enable=0 in any state → IDLE next cycle; locked cleared; other outputs hold.
- ARM (waiting for the first rise):
  - period_ctr increments each cycle, saturating at TIMEOUT.
  - rise → MEASURE: period_ctr=1, high_ctr=1. No valid pulse, because the first edge gives no full period.
- MEASURE, each cycle without rise:
  - period_ctr+1.
  - high_ctr+1 if s2=1 and no fall has been seen since the last rise; high_ctr freezes after fall.
- MEASURE, rise:
  - high_cnt ← high_ctr; period_cnt ← period_ctr.
  - compare_out ← min(high_ctr, 2^CTR_LEN−1).
  - locked ← (period_ctr == 2^CTR_LEN).
  - stuck_low/stuck_high ← 0; valid=1 next cycle.
  - Then period_ctr=1, high_ctr=1; stay in MEASURE.
- Timeout (state ARM or MEASURE, period_ctr == TIMEOUT, no rise this cycle):
  - If s2=0: stuck_low=1, compare_out=0.
  - If s2=1: stuck_high=1, compare_out=all ones.
  - In both cases: locked=0, high_cnt and period_cnt hold, valid pulses once.
  - Next state is ARM with period_ctr held at TIMEOUT, so there is no repeat pulse while the line stays stuck.
  - A later rise in ARM clears stuck_* and restarts measurement; the first valid comes one period later.
- Simultaneous events:
  - rise and timeout in the same cycle → rise wins.
  - rise and fall cannot coincide.
- Latency: a pin rise before clk edge k gives valid=1 and updated outputs after edge k+2.
- All outputs are registered. valid is never high for two consecutive cycles except for back-to-back rises, which are impossible with a 2-cycle minimum pulse.

Test Plan:
- Steady code: drive 16 high / 48 low repeating → from the second rise on, each rise gives valid with high_cnt=16, period_cnt=64, compare_out=16, locked=1.
- Extremes: 1 high / 63 low → compare_out=1, locked=1. 63 high / 1 low → compare_out=63, locked=1.
- Stuck line: after 10/54 lock, hold pwm_in low → when period_ctr reaches 128, one valid pulse with stuck_low=1, compare_out=0, locked=0 and no further pulses. Hold high instead → stuck_high=1, compare_out=63.
- Off-nominal: 80 high / 100 period → high_cnt=80, period_cnt=100, compare_out=63, locked=0.
- Reset/enable: assert reset mid-high-phase → outputs 0 immediately, no clk needed. Drop enable for 5 cycles → locked=0. After re-enable, the first valid arrives only after two rises.
- Latency: toggle pwm_in synchronously before edge k at the second rise → valid observed after edge k+2 exactly.

Source files
------------

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM receiver: measures high time and rise-to-rise period,
// recovers the compare code, flags lock and a stuck-low/stuck-high line.
module pwm_capture #(
  parameter int CTR_LEN = 6,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 128
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               enable_i,
  input  logic               pwm_in_i,
  output logic [CNT_W-1:0]   high_cnt_o,
  output logic [CNT_W-1:0]   period_cnt_o,
  output logic [CTR_LEN-1:0] compare_out_o,
  output logic               valid_o,
  output logic               locked_o,
  output logic               stuck_low_o,
  output logic               stuck_high_o
);

  localparam logic [CNT_W-1:0] TimeoutC  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] NominalC  = CNT_W'(2 ** CTR_LEN);
  localparam logic [CNT_W-1:0] CodeMaxC  = CNT_W'((2 ** CTR_LEN) - 1);
  localparam logic [CNT_W-1:0] OneC      = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t               state_q, state_d;
  logic                 s1_q, s2_q, s3_q;
  logic [CNT_W-1:0]     period_ctr_q, period_ctr_d;
  logic [CNT_W-1:0]     high_ctr_q, high_ctr_d;
  logic                 fall_seen_q, fall_seen_d;
  logic                 timed_out_q, timed_out_d;
  logic [CNT_W-1:0]     high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]     period_cnt_q, period_cnt_d;
  logic [CTR_LEN-1:0]   compare_q, compare_d;
  logic                 valid_q, valid_d;
  logic                 locked_q, locked_d;
  logic                 stuck_low_q, stuck_low_d;
  logic                 stuck_high_q, stuck_high_d;

  logic rise, fall, timeout_hit;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;
  // timed_out_q keeps a held-at-TIMEOUT counter from re-triggering while the line stays stuck
  assign timeout_hit = (period_ctr_q == TimeoutC) && !timed_out_q;

  always_comb begin
    state_d      = state_q;
    period_ctr_d = period_ctr_q;
    high_ctr_d   = high_ctr_q;
    fall_seen_d  = fall_seen_q;
    timed_out_d  = timed_out_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    compare_d    = compare_q;
    valid_d      = 1'b0;
    locked_d     = locked_q;
    stuck_low_d  = stuck_low_q;
    stuck_high_d = stuck_high_q;

    if (!enable_i) begin
      state_d      = IDLE;
      period_ctr_d = '0;
      high_ctr_d   = '0;
      fall_seen_d  = 1'b0;
      timed_out_d  = 1'b0;
      locked_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d      = ARM;
          period_ctr_d = '0;
          high_ctr_d   = '0;
        end

        ARM: begin
          if (rise) begin
            state_d      = MEASURE;
            period_ctr_d = OneC;
            high_ctr_d   = OneC;
            fall_seen_d  = 1'b0;
            timed_out_d  = 1'b0;
            stuck_low_d  = 1'b0;
            stuck_high_d = 1'b0;
          end else if (timeout_hit) begin
            timed_out_d  = 1'b1;
            valid_d      = 1'b1;
            locked_d     = 1'b0;
            stuck_low_d  = ~s2_q;
            stuck_high_d = s2_q;
            compare_d    = s2_q ? '1 : '0;
          end else if (period_ctr_q != TimeoutC) begin
            period_ctr_d = period_ctr_q + OneC;
          end
        end

        MEASURE: begin
          if (rise) begin
            high_cnt_d   = high_ctr_q;
            period_cnt_d = period_ctr_q;
            compare_d    = (high_ctr_q > CodeMaxC) ? CodeMaxC[CTR_LEN-1:0]
                                                   : high_ctr_q[CTR_LEN-1:0];
            locked_d     = (period_ctr_q == NominalC);
            stuck_low_d  = 1'b0;
            stuck_high_d = 1'b0;
            valid_d      = 1'b1;
            period_ctr_d = OneC;
            high_ctr_d   = OneC;
            fall_seen_d  = 1'b0;
          end else if (timeout_hit) begin
            state_d      = ARM;
            timed_out_d  = 1'b1;
            valid_d      = 1'b1;
            locked_d     = 1'b0;
            stuck_low_d  = ~s2_q;
            stuck_high_d = s2_q;
            compare_d    = s2_q ? '1 : '0;
          end else begin
            period_ctr_d = period_ctr_q + OneC;
            if (fall) begin
              fall_seen_d = 1'b1;
            end else if (s2_q && !fall_seen_q) begin
              high_ctr_d = high_ctr_q + OneC;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      period_ctr_q <= '0;
      high_ctr_q   <= '0;
      fall_seen_q  <= 1'b0;
      timed_out_q  <= 1'b0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      compare_q    <= '0;
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
      stuck_low_q  <= 1'b0;
      stuck_high_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= pwm_in_i;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      period_ctr_q <= period_ctr_d;
      high_ctr_q   <= high_ctr_d;
      fall_seen_q  <= fall_seen_d;
      timed_out_q  <= timed_out_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      compare_q    <= compare_d;
      valid_q      <= valid_d;
      locked_q     <= locked_d;
      stuck_low_q  <= stuck_low_d;
      stuck_high_q <= stuck_high_d;
    end
  end

  assign high_cnt_o    = high_cnt_q;
  assign period_cnt_o  = period_cnt_q;
  assign compare_out_o = compare_q;
  assign valid_o       = valid_q;
  assign locked_o      = locked_q;
  assign stuck_low_o   = stuck_low_q;
  assign stuck_high_o  = stuck_high_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - bench for pwm_capture: pulse-train model of expected
// measurements, stuck-line, enable, latency and async-reset scenarios.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        pwm = 1'b0;
  logic [15:0] high_cnt, period_cnt;
  logic [5:0]  compare_out;
  logic        valid, locked, stuck_low, stuck_high;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] p;
    logic [5:0]  c;
    logic        lk;
    logic        sl;
    logic        sh;
  } rec_t;

  rec_t dut_q[$];
  int   hq[$];
  int   lq[$];
  int   b2b_cnt = 0;
  logic prev_valid = 1'b0;

  pwm_capture #(.CTR_LEN(6), .CNT_W(16), .TIMEOUT(128)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .enable_i     (enable),
    .pwm_in_i     (pwm),
    .high_cnt_o   (high_cnt),
    .period_cnt_o (period_cnt),
    .compare_out_o(compare_out),
    .valid_o      (valid),
    .locked_o     (locked),
    .stuck_low_o  (stuck_low),
    .stuck_high_o (stuck_high)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) dut_q.push_back({high_cnt, period_cnt, compare_out, locked, stuck_low, stuck_high});
    if (valid && prev_valid) b2b_cnt++;
    prev_valid = valid;
  end

  // Reference: a pulse of h high cycles followed by l low cycles is reported at the next rise.
  function automatic rec_t model(int h, int l);
    rec_t r;
    r.h  = 16'(h);
    r.p  = 16'(h + l);
    r.c  = (h > 63) ? 6'd63 : 6'(h);
    r.lk = ((h + l) == 64);
    r.sl = 1'b0;
    r.sh = 1'b0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pulse(int h, int l);
    pwm = 1'b1;
    repeat (h) tick();
    pwm = 1'b0;
    repeat (l) tick();
  endtask

  task automatic restart();
    enable = 1'b0;
    pwm = 1'b0;
    repeat (5) tick();
    enable = 1'b1;
    repeat (2) tick();
    dut_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({high_cnt, period_cnt, compare_out, valid, locked, stuck_low, stuck_high} !== 0) begin
      miscompares++;
      $display("FAIL reset_state: got h=%0d p=%0d c=%0d v=%b lk=%b sl=%b sh=%b, need all 0",
               high_cnt, period_cnt, compare_out, valid, locked, stuck_low, stuck_high);
    end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_train(string name);
    rec_t got, exp;
    int n;
    restart();
    foreach (hq[i]) drive_pulse(hq[i], lq[i]);
    pwm = 1'b1;
    repeat (4) tick();
    vectors++;
    if (dut_q.size() != hq.size()) begin
      miscompares++;
      $display("FAIL %s_count: got %0d valids, need %0d", name, dut_q.size(), hq.size());
    end
    n = (dut_q.size() < hq.size()) ? dut_q.size() : hq.size();
    for (int i = 0; i < n; i++) begin
      got = dut_q[i];
      exp = model(hq[i], lq[i]);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s[%0d]: got h=%0d p=%0d c=%0d lk=%b sl=%b sh=%b, need h=%0d p=%0d c=%0d lk=%b sl=%b sh=%b",
                 name, i, got.h, got.p, got.c, got.lk, got.sl, got.sh,
                 exp.h, exp.p, exp.c, exp.lk, exp.sl, exp.sh);
      end
    end
  endtask

  task automatic test_steady();
    hq.delete(); lq.delete();
    for (int i = 0; i < 6; i++) begin hq.push_back(16); lq.push_back(48); end
    test_train("steady");
  endtask

  task automatic test_extremes();
    hq.delete(); lq.delete();
    for (int i = 0; i < 3; i++) begin hq.push_back(1);  lq.push_back(63); end
    for (int i = 0; i < 3; i++) begin hq.push_back(63); lq.push_back(1);  end
    test_train("extremes");
  endtask

  task automatic test_off_nominal();
    hq.delete(); lq.delete();
    for (int i = 0; i < 2; i++) begin hq.push_back(80); lq.push_back(20); end
    test_train("off_nominal");
  endtask

  task automatic test_random();
    int h;
    hq.delete(); lq.delete();
    for (int i = 0; i < 20; i++) begin
      h = int'($urandom_range(1, 90));
      hq.push_back(h);
      lq.push_back(int'($urandom_range(1, 120 - h)));
    end
    test_train("random");
  endtask

  task automatic test_stuck_low();
    rec_t exp;
    restart();
    for (int i = 0; i < 3; i++) drive_pulse(10, 54);
    repeat (200) tick();
    vectors++;
    if (dut_q.size() != 3) begin
      miscompares++;
      $display("FAIL stuck_low_count: got %0d valids, need 3", dut_q.size());
    end else begin
      exp = model(10, 54);
      exp.c = 6'd0; exp.lk = 1'b0; exp.sl = 1'b1;
      vectors++;
      if (dut_q[2] !== exp) begin
        miscompares++;
        $display("FAIL stuck_low_rec: got h=%0d p=%0d c=%0d lk=%b sl=%b sh=%b, need h=10 p=64 c=0 lk=0 sl=1 sh=0",
                 dut_q[2].h, dut_q[2].p, dut_q[2].c, dut_q[2].lk, dut_q[2].sl, dut_q[2].sh);
      end
    end
    pwm = 1'b1;
    repeat (4) tick();
    vectors++;
    if (stuck_low !== 1'b0 || dut_q.size() != 3) begin
      miscompares++;
      $display("FAIL stuck_recover_rise: got sl=%b valids=%0d, need sl=0 valids=3", stuck_low, dut_q.size());
    end
    repeat (12) tick();
    pwm = 1'b0;
    repeat (48) tick();
    pwm = 1'b1;
    repeat (4) tick();
    vectors++;
    if (dut_q.size() != 4 || dut_q[dut_q.size()-1] !== model(16, 48)) begin
      miscompares++;
      $display("FAIL stuck_recover_meas: got valids=%0d h=%0d p=%0d, need valids=4 h=16 p=64",
               dut_q.size(), high_cnt, period_cnt);
    end
  endtask

  task automatic test_stuck_high();
    rec_t exp;
    restart();
    for (int i = 0; i < 3; i++) drive_pulse(10, 54);
    pwm = 1'b1;
    repeat (200) tick();
    vectors++;
    if (dut_q.size() != 4) begin
      miscompares++;
      $display("FAIL stuck_high_count: got %0d valids, need 4", dut_q.size());
    end else begin
      exp = model(10, 54);
      exp.c = 6'd63; exp.lk = 1'b0; exp.sh = 1'b1;
      vectors++;
      if (dut_q[3] !== exp) begin
        miscompares++;
        $display("FAIL stuck_high_rec: got h=%0d p=%0d c=%0d lk=%b sl=%b sh=%b, need h=10 p=64 c=63 lk=0 sl=0 sh=1",
                 dut_q[3].h, dut_q[3].p, dut_q[3].c, dut_q[3].lk, dut_q[3].sl, dut_q[3].sh);
      end
    end
  endtask

  task automatic test_enable();
    restart();
    for (int i = 0; i < 3; i++) drive_pulse(16, 48);
    pwm = 1'b1;
    repeat (4) tick();
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("FAIL enable_prelock: got locked=%b, need 1", locked);
    end
    enable = 1'b0;
    repeat (5) tick();
    vectors++;
    if (locked !== 1'b0 || high_cnt !== 16'd16) begin
      miscompares++;
      $display("FAIL enable_drop: got locked=%b h=%0d, need locked=0 h=16", locked, high_cnt);
    end
    enable = 1'b1;
    dut_q.delete();
    pwm = 1'b0;
    repeat (10) tick();
    drive_pulse(16, 48);
    vectors++;
    if (dut_q.size() != 0) begin
      miscompares++;
      $display("FAIL enable_first_rise: got %0d valids, need 0", dut_q.size());
    end
    pwm = 1'b1;
    repeat (4) tick();
    vectors++;
    if (dut_q.size() != 1 || dut_q[0] !== model(16, 48)) begin
      miscompares++;
      $display("FAIL enable_second_rise: got valids=%0d h=%0d p=%0d, need valids=1 h=16 p=64",
               dut_q.size(), high_cnt, period_cnt);
    end
  endtask

  task automatic test_latency();
    logic [3:0] seen;
    restart();
    drive_pulse(16, 48);
    pwm = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      seen[k] = valid;
    end
    vectors++;
    if (seen !== 4'b0100 || high_cnt !== 16'd16 || period_cnt !== 16'd64) begin
      miscompares++;
      $display("FAIL latency: got valid after k..k+3=%b h=%0d p=%0d, need 0100 h=16 p=64",
               {seen[0], seen[1], seen[2], seen[3]}, high_cnt, period_cnt);
    end
  endtask

  task automatic test_async_reset();
    restart();
    for (int i = 0; i < 2; i++) drive_pulse(16, 48);
    pwm = 1'b1;
    repeat (6) tick();
    vectors++;
    if (high_cnt !== 16'd16 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset_pre: got h=%0d locked=%b, need h=16 locked=1", high_cnt, locked);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({high_cnt, period_cnt, compare_out, valid, locked, stuck_low, stuck_high} !== 0) begin
      miscompares++;
      $display("FAIL async_reset: got h=%0d p=%0d c=%0d v=%b lk=%b sl=%b sh=%b, need all 0",
               high_cnt, period_cnt, compare_out, valid, locked, stuck_low, stuck_high);
    end
    #8 reset_n = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_steady();
    test_extremes();
    test_off_nominal();
    test_random();
    test_stuck_low();
    test_stuck_high();
    test_enable();
    test_latency();
    test_async_reset();
    vectors++;
    if (b2b_cnt != 0) begin
      miscompares++;
      $display("FAIL valid_back_to_back: got %0d double pulses, need 0", b2b_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
